// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction fetch front end.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & INSTR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// Power-of-two FIFO of fetched {pc, instr} entries with a synchronous flush.
module fetchq_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_entry,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns fetch PC, issues sequential imem reads, buffers results.
// Optional FETCHQ_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   issued_pc;
    logic [31:0]   last_pc;
    logic          inflight;
    logic          drop;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          credit_ok;
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;
    logic          full;
    logic          empty;
    logic          resp_ok;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [31:0]   shown_pc;
    logic [31:0]   shown_instr;

    // Outstanding read counts against capacity so a response always finds room.
    assign credit_used = {1'b0, count} + (CW+1)'(inflight);
    assign credit_ok   = credit_used < (CW+1)'(DEPTH);
    assign imem_req_o  = rst && !redirect_i && credit_ok;
    assign imem_addr_o = fetch_pc;

    assign resp_ok = imem_rvalid_i && inflight && !drop && !redirect_i;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = resp_ok && empty && ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push     = resp_ok && !bypass;
    assign pop      = !empty && ready_i && !redirect_i;
    assign wr_entry = '{pc: issued_pc, instr: imem_rdata_i};

    assign valid_o     = (!empty && !redirect_i) || bypass;
    assign shown_pc    = bypass ? issued_pc    : head.pc;
    assign shown_instr = bypass ? imem_rdata_i : head.instr;
    assign instr_o     = valid_o ? shown_instr : NOP_INSTR;
    assign pc_o        = valid_o ? shown_pc    : last_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            drop     <= 1'b0;
            last_pc  <= '0;
        end else begin
            inflight <= imem_req_o;
            if (redirect_i) begin
                fetch_pc <= align_pc(redirect_pc_i);
            end else if (imem_req_o) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            // A read still outstanding past the redirect must not reach the FIFO.
            if (redirect_i) begin
                drop <= inflight && !imem_rvalid_i;
            end else if (imem_rvalid_i) begin
                drop <= 1'b0;
            end
            if (valid_o) last_pc <= shown_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req_o) issued_pc <= fetch_pc;
    end

    fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_i),
        .wr_entry (wr_entry),
        .count    (count),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCHQ_BYPASS_EN
    localparam int FIRST_VALID = 1;
`else
    localparam int FIRST_VALID = 2;
`endif

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } snap_t;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int checks;
    int failures;

    // memory responder state and reference model state
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [31:0] mq[$];
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    function automatic snap_t reset_snap();
        return '{req: 1'b0, addr: RESET_PC, valid: 1'b0, instr: NOP, pc: 32'h0};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_pc      = RESET_PC;
        m_last_pc = '0;
    endtask

    // One clock cycle: apply inputs, sample outputs, advance the model.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy,
                        output snap_t o, output snap_t e);
        logic resp;
        logic byp;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        ready_i       = rdy;
        imem_rvalid_i = mem_valid;
        imem_rdata_i  = mem_data;
        #1;
        o = '{req: imem_req_o, addr: imem_addr_o, valid: valid_o, instr: instr_o, pc: pc_o};
        resp = mem_valid && m_pend && !redir;
        byp  = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = resp && (mq.size() == 0) && rdy;
`endif
        e.req  = !redir && ((mq.size() + int'(m_pend)) < DEPTH);
        e.addr = m_pc;
        if (byp) begin
            e.valid = 1'b1; e.pc = m_pend_pc; e.instr = mem_word(m_pend_pc);
        end else if (mq.size() > 0 && !redir) begin
            e.valid = 1'b1; e.pc = mq[0]; e.instr = mem_word(mq[0]);
        end else begin
            e.valid = 1'b0; e.pc = m_last_pc; e.instr = NOP;
        end
        if (e.valid) m_last_pc = e.pc;
        if (redir) begin
            mq.delete();
            m_pc   = rpc & 32'hFFFF_FFFC;
            m_pend = 1'b0;
        end else begin
            if (e.valid && rdy && !byp) void'(mq.pop_front());
            if (resp && !byp) mq.push_back(m_pend_pc);
            if (e.req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
            m_pend = e.req;
        end
        mem_valid = imem_req_o;
        mem_data  = mem_word(imem_addr_o);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ready_i       = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        mem_valid     = 1'b0;
        mem_data      = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        snap_t o;
        rst = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        o = '{req: imem_req_o, addr: imem_addr_o, valid: valid_o, instr: instr_o, pc: pc_o};
        checks++;
        if (o !== reset_snap()) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h", o, reset_snap());
        end
    endtask

    task automatic test_stream();
        snap_t o, e;
        int    n_pop;
        apply_reset();
        n_pop = 0;
        for (int c = 0; c < 24; c++) begin
            step(1'b0, '0, 1'b1, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stream_cyc%0d got=%h want=%h", c, o, e);
            end
            if (c == FIRST_VALID) begin
                checks++;
                if (!(o.valid === 1'b1 && o.pc === 32'h0)) begin
                    failures++;
                    $display("FAIL stream_first_valid got v=%b pc=%h want v=1 pc=0", o.valid, o.pc);
                end
            end
            if (o.valid === 1'b1) begin
                checks++;
                if (o.pc !== 32'(n_pop * 4)) begin
                    failures++;
                    $display("FAIL stream_seq got=%h want=%h", o.pc, 32'(n_pop * 4));
                end
                n_pop++;
            end
        end
    endtask

    task automatic test_full();
        snap_t o, e;
        int    n_req, n_pop;
        apply_reset();
        n_req = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, '0, 1'b0, o, e);
            if (o.req === 1'b1) n_req++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL full_hold_cyc%0d got=%h want=%h", c, o, e);
            end
        end
        checks++;
        if (n_req != DEPTH) begin
            failures++;
            $display("FAIL full_req_count got=%0d want=%0d", n_req, DEPTH);
        end
        n_pop = 0;
        for (int c = 0; c < 8 && n_pop < 4; c++) begin
            step(1'b0, '0, 1'b1, o, e);
            if (o.valid === 1'b1) begin
                checks++;
                if (o.pc !== 32'(n_pop * 4) || o.instr !== mem_word(32'(n_pop * 4))) begin
                    failures++;
                    $display("FAIL full_drain got pc=%h instr=%h want pc=%h", o.pc, o.instr, 32'(n_pop * 4));
                end
                n_pop++;
            end
        end
        checks++;
        if (n_pop != 4) begin
            failures++;
            $display("FAIL full_drain_count got=%0d want=4", n_pop);
        end
    endtask

    task automatic test_redirect();
        snap_t o, e;
        bit    seen;
        apply_reset();
        step(1'b0, '0, 1'b1, o, e);
        step(1'b0, '0, 1'b1, o, e);
        // previous cycle issued a request, so its response lands in the redirect cycle
        checks++;
        if (o.req !== 1'b1) begin
            failures++;
            $display("FAIL redir_pre_req got=%b want=1", o.req);
        end
        step(1'b1, 32'h0000_0102, 1'b1, o, e);
        step(1'b0, '0, 1'b1, o, e);
        checks++;
        if (o.req !== 1'b1 || o.addr !== 32'h0000_0100) begin
            failures++;
            $display("FAIL redir_addr got req=%b addr=%h want req=1 addr=00000100", o.req, o.addr);
        end
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            step(1'b0, '0, 1'b1, o, e);
            if (o.valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (o.pc !== 32'h0000_0100) begin
                    failures++;
                    $display("FAIL redir_first_pc got=%h want=00000100", o.pc);
                end
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL redir_timeout got no valid_o want valid within 6 cycles");
        end
    endtask

    task automatic test_redirect_pop();
        snap_t o, e;
        int    guard;
        apply_reset();
        guard = 0;
        while (!(mq.size() == 2 && m_pend) && guard < 10) begin
            step(1'b0, '0, 1'b0, o, e);
            guard++;
        end
        checks++;
        if (!(mq.size() == 2 && m_pend)) begin
            failures++;
            $display("FAIL rpop_setup got size=%0d want 2", mq.size());
        end
        step(1'b1, 32'h0000_0200, 1'b1, o, e);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL rpop_redir_cyc got=%h want=%h", o, e);
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, '0, 1'b1, o, e);
            checks++;
            if (o !== e || (o.valid === 1'b1 && o.pc < 32'h0000_0200)) begin
                failures++;
                $display("FAIL rpop_after_cyc%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_wrap();
        snap_t o, e;
        apply_reset();
        step(1'b1, 32'hFFFF_FFFE, 1'b1, o, e);
        step(1'b0, '0, 1'b1, o, e);
        checks++;
        if (o.req !== 1'b1 || o.addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_align got req=%b addr=%h want req=1 addr=fffffffc", o.req, o.addr);
        end
        step(1'b0, '0, 1'b1, o, e);
        checks++;
        if (o.req !== 1'b1 || o.addr !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap_next got req=%b addr=%h want req=1 addr=00000000", o.req, o.addr);
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, '0, 1'b1, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL wrap_cyc%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_random();
        snap_t       o, e;
        logic        redir, rdy;
        logic [31:0] rpc;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            redir = ($urandom_range(0, 7) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            rpc   = $urandom;
            step(redir, rpc, rdy, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random_cyc%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        snap_t o, e;
        apply_reset();
        for (int c = 0; c < 5; c++) step(1'b0, '0, ($urandom_range(0, 1) == 1), o, e);
        #2;
        rst = 1'b0;
        redirect_i = 1'b0;
        #1;
        o = '{req: imem_req_o, addr: imem_addr_o, valid: valid_o, instr: instr_o, pc: pc_o};
        checks++;
        if (o !== reset_snap()) begin
            failures++;
            $display("FAIL midreset_values got=%h want=%h", o, reset_snap());
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        // stale response from before reset must be ignored
        mem_valid = 1'b1;
        mem_data  = 32'hDEAD_BEEF;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, '0, 1'b1, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midreset_cyc%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the pipelined core. It owns the fetch PC, issues sequential reads to the instruction memory port and buffers returned instructions, with their PCs, in a small FIFO. It presents them to the IF/ID register through a valid/ready handshake. Redirects from EX (branch taken, JAL, JALR) flush the buffer and discard any read still in flight, which decouples instruction-memory latency from decode stalls.

## Interface
- DEPTH, 4, number of buffered entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- imem_req_o  out  1  read request this cycle
- imem_addr_o  out  32  read address; bits [1:0] always 0
- imem_rvalid_i  in  1  read data valid; always exactly 1 cycle after imem_req_o
- imem_rdata_i  in  32  read data
- redirect_i  in  1  taken branch/JAL/JALR from EX
- redirect_pc_i  in  32  new fetch target; bits [1:0] are forced to 0
- valid_o  out  1  head entry available to decode
- ready_i  in  1  decode accepts the head entry (driven from IF_ID_Write)
- instr_o  out  32  head instruction
- pc_o  out  32  PC of the head instruction

## Operation
- Internal state:
  - fetch_pc (32 bits)
  - FIFO of {pc, instr} with rd/wr pointers and count (0..DEPTH)
  - inflight flag
  - drop flag
- Request rule: imem_req_o = !redirect_i && (count + inflight < DEPTH).
  - imem_addr_o = fetch_pc.
  - On request: fetch_pc += 4 (mod 2^32 wrap), inflight set for 1 cycle.
- Response rule: when imem_rvalid_i=1 and drop=0 and redirect_i=0, push {PC of the issuing request, imem_rdata_i}.
  - The issued PC is held in a register.
- Pop: valid_o && ready_i advances the read pointer.
- Simultaneous push and pop updates count by 0 and is legal at any fill level.
- The credit rule guarantees a push can never find the FIFO full. A push into a full FIFO is an assertion failure.
- Redirect (redirect_i=1) has priority over every other event in the same cycle:
  - count and pointers are cleared, and any same-cycle pop or push is ignored;
  - fetch_pc is loaded with {redirect_pc_i[31:2], 2'b00};
  - drop is set if a request was issued in that cycle, so its response is discarded;
  - no request is issued in the redirect cycle.
- drop clears on the cycle its response is discarded.
- Consecutive redirects: the last one wins; each suppresses requests in its own cycle.
- When valid_o=0: instr_o = 32'h0000_0013 (NOP) and pc_o holds its last value.

## Timing
- Reset values:
  - imem_req_o=0, imem_addr_o=RESET_PC
  - valid_o=0, instr_o=NOP, pc_o=0
  - count=0, inflight=0, drop=0, fetch_pc=RESET_PC
- First request is in the first clk edge cycle after rst deasserts.
- Fetch latency, without bypass: request in cycle N, rvalid in N+1, valid_o in N+2.
- Redirect penalty: redirect in cycle R, request in R+1, valid_o in R+3 (R+2 with bypass).
- Steady-state throughput: 1 instruction/cycle while ready_i=1.
- Asserting reset mid-operation clears all state immediately. Any response arriving after reset release and before the first new request is ignored, because inflight=0.

## Configuration
- FETCHQ_BYPASS_EN defined:
  - when the FIFO is empty, the response is accepted and ready_i=1, the response drives valid_o/instr_o/pc_o combinationally in its rvalid cycle and is not written to the FIFO;
  - if ready_i=0, it is pushed as normal.
- Undefined: every response goes through the FIFO, giving one extra cycle of latency.

## Structure
- Shared package pipe_pkg:
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}
  - NOP_INSTR = 32'h0000_0013
  - INSTR_ALIGN_MASK
- Sub-module fetchq_fifo:
  - parameterised by DEPTH, storing fetch_entry_t;
  - ports push, pop, flush, count, head, full, empty.
- Fetch-PC, credit and drop logic stay in fetch_queue.

## Test plan
- Reset then ready_i=1, memory returns PC-tagged data → valid_o from cycle 2; pc_o sequence 0,4,8,… with one entry per cycle.
- ready_i=0 for 10 cycles after reset → exactly DEPTH=4 requests issued, then imem_req_o=0. On release, entries 0,4,8,12 pop in order with none lost or duplicated.
- redirect_i=1 with redirect_pc_i=32'h0000_0102 while a request is in flight → the in-flight response is dropped, the next imem_addr_o is 0x100, and the first valid pc_o after the redirect is 0x100.
- Redirect coincident with pop and rvalid at count=2 → count=0 afterwards and none of the three old entries ever appears on the output.
- fetch_pc=32'hFFFF_FFFC → the next request address is 0x0000_0000 (wrap).
- With FETCHQ_BYPASS_EN: empty FIFO, ready_i=1 → valid_o is high in the same cycle as imem_rvalid_i, carrying the matching instr and pc.
